// File: rtl/systolic_array_skewed.sv
// systolic_array_skewed: ROWS x COLS output-stationary MAC grid.
// Operands arrive unskewed. Internal delay lines stagger the A lanes and the B lanes.
// A small FSM runs LOAD / FLUSH / DRAIN, and results are read back one row per handshake.
module systolic_array_skewed #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 40,
   parameter int K_MAX     = 256,
   parameter int KW        = $clog2(K_MAX + 1)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [KW-1:0]                          k_len,
   input  logic                                   is_signed,
   input  logic                                   acc_keep,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [ROWS*WIDTH-1:0]                  in_a,
   input  logic [COLS*WIDTH-1:0]                  in_b,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [COLS*ACC_WIDTH-1:0]              out_row,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
   output logic                                   busy,
   output logic                                   done
);

   localparam int RIW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FLUSH_LEN = ROWS + COLS - 2;
   localparam int FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [KW-1:0]        k_eff, k_lat, beat_cnt;
   logic [FW-1:0]        flush_cnt;
   logic [RIW-1:0]       row_idx;
   logic                 sgn_q, done_q;
   logic                 launch, step;

   logic [WIDTH-1:0]     inj_a [ROWS];
   logic [WIDTH-1:0]     inj_b [COLS];
   logic [WIDTH-1:0]     a_sk  [ROWS][ROWS];
   logic [WIDTH-1:0]     b_sk  [COLS][COLS];
   logic [WIDTH-1:0]     a_ent [ROWS];
   logic [WIDTH-1:0]     b_ent [COLS];
   logic [WIDTH-1:0]     a_reg [ROWS][COLS];
   logic [WIDTH-1:0]     b_reg [ROWS][COLS];
   logic [WIDTH-1:0]     a_in  [ROWS][COLS];
   logic [WIDTH-1:0]     b_in  [ROWS][COLS];
   logic [ACC_WIDTH-1:0] acc   [ROWS][COLS];

   // Extend both operands by one bit according to the sign mode, then take the full product.
   function automatic logic [ACC_WIDTH-1:0] mac_prod(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic             sgn);
      logic signed [WIDTH:0]       ax, bx;
      logic signed [2*WIDTH+1:0]   p;
      ax = signed'({sgn & a[WIDTH-1], a});
      bx = signed'({sgn & b[WIDTH-1], b});
      p  = (2*WIDTH+2)'(ax) * (2*WIDTH+2)'(bx);
      return ACC_WIDTH'(p);
   endfunction

   assign k_eff  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
   assign launch = (state_q == IDLE) && start;
   assign step   = ((state_q == LOAD) && in_valid) || (state_q == FLUSH);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and the handshake outputs, all taken from the registered state.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (start) state_d = (k_eff == '0) ? DRAIN : LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (beat_cnt == k_lat - KW'(1)))
               state_d = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
         end
         FLUSH: begin
            if (flush_cnt == FW'(FLUSH_LEN - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (row_idx == RIW'(ROWS - 1))) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Run parameters, beat/flush/drain counters and the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         k_lat     <= '0;
         sgn_q     <= 1'b0;
         beat_cnt  <= '0;
         flush_cnt <= '0;
         row_idx   <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  k_lat     <= k_eff;
                  sgn_q     <= is_signed;
                  beat_cnt  <= '0;
                  flush_cnt <= '0;
                  row_idx   <= '0;
               end
            end
            LOAD: begin
               if (in_valid) beat_cnt <= beat_cnt + KW'(1);
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + FW'(1);
            end
            DRAIN: begin
               if (out_ready) begin
                  if (row_idx == RIW'(ROWS - 1)) begin
                     row_idx <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     row_idx <= row_idx + RIW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Operands injected into the skew lines: live lanes in LOAD, zeros while flushing.
   always_comb begin
      for (int unsigned r = 0; r < ROWS; r++)
         inj_a[r] = (state_q == LOAD) ? in_a[r*WIDTH +: WIDTH] : '0;
      for (int unsigned c = 0; c < COLS; c++)
         inj_b[c] = (state_q == LOAD) ? in_b[c*WIDTH +: WIDTH] : '0;
   end

   // Edge PEs take the lane delayed by its index. Interior PEs take the neighbour's registered operand.
   // Each PE multiplies the operands arriving on this step, so a beat reaches PE(r,c) after exactly r+c steps.
   for (genvar r = 0; r < ROWS; r++) begin : g_a_ent
      if (r == 0) begin : g_direct
         assign a_ent[r] = inj_a[r];
      end else begin : g_delayed
         assign a_ent[r] = a_sk[r][r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b_ent
      if (c == 0) begin : g_direct
         assign b_ent[c] = inj_b[c];
      end else begin : g_delayed
         assign b_ent[c] = b_sk[c][c-1];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         if (c == 0) begin : g_a_edge
            assign a_in[r][c] = a_ent[r];
         end else begin : g_a_inner
            assign a_in[r][c] = a_reg[r][c-1];
         end
         if (r == 0) begin : g_b_edge
            assign b_in[r][c] = b_ent[c];
         end else begin : g_b_inner
            assign b_in[r][c] = b_reg[r-1][c];
         end
      end
   end

   // Skew lines, PE operand registers and accumulators all advance together, once per array step.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned j = 0; j < ROWS; j++) a_sk[r][j] <= '0;
            for (int unsigned c = 0; c < COLS; c++) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
               acc[r][c]   <= '0;
            end
         end
         for (int unsigned c = 0; c < COLS; c++)
            for (int unsigned j = 0; j < COLS; j++) b_sk[c][j] <= '0;
      end else if (launch) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned j = 0; j < ROWS; j++) a_sk[r][j] <= '0;
            for (int unsigned c = 0; c < COLS; c++) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
               if (!acc_keep) acc[r][c] <= '0;
            end
         end
         for (int unsigned c = 0; c < COLS; c++)
            for (int unsigned j = 0; j < COLS; j++) b_sk[c][j] <= '0;
      end else if (step) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            a_sk[r][0] <= inj_a[r];
            for (int unsigned j = 1; j < ROWS; j++) a_sk[r][j] <= a_sk[r][j-1];
         end
         for (int unsigned c = 0; c < COLS; c++) begin
            b_sk[c][0] <= inj_b[c];
            for (int unsigned j = 1; j < COLS; j++) b_sk[c][j] <= b_sk[c][j-1];
         end
         for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
               a_reg[r][c] <= a_in[r][c];
               b_reg[r][c] <= b_in[r][c];
               acc[r][c]   <= acc[r][c] + mac_prod(a_in[r][c], b_in[r][c], sgn_q);
            end
         end
      end
   end

   // Row-serial result mux.
   always_comb begin
      out_row = '0;
      for (int unsigned c = 0; c < COLS; c++)
         out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][c];
   end

   assign out_row_idx = row_idx;
   assign done        = done_q;

endmodule

// File: tb/tb_systolic_array_skewed.sv
// Directed testbench for systolic_array_skewed (4x4, WIDTH=16, ACC_WIDTH=40).
module tb_systolic_array_skewed;

   localparam int ROWS      = 4;
   localparam int COLS      = 4;
   localparam int WIDTH     = 16;
   localparam int ACC_WIDTH = 40;
   localparam int K_MAX     = 256;
   localparam int KW        = $clog2(K_MAX + 1);

   logic                         clk = 1'b0;
   logic                         reset, start, is_signed, acc_keep, in_valid, out_ready;
   logic [KW-1:0]                k_len;
   logic                         in_ready, out_valid, busy, done;
   logic [ROWS*WIDTH-1:0]        in_a;
   logic [COLS*WIDTH-1:0]        in_b;
   logic [COLS*ACC_WIDTH-1:0]    out_row;
   logic [1:0]                   out_row_idx;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0]     op_a  [K_MAX][ROWS];
   logic [WIDTH-1:0]     op_b  [K_MAX][COLS];
   logic [ACC_WIDTH-1:0] exp_c [ROWS][COLS];

   systolic_array_skewed #(
      .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .K_MAX(K_MAX), .KW(KW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .is_signed(is_signed),
      .acc_keep(acc_keep), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_row_idx(out_row_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic start_run(input int k, input logic sgn, input logic keep);
      @(negedge clk);
      chk("idle_before_start", busy, 1'b0);
      start = 1'b1; k_len = KW'(k); is_signed = sgn; acc_keep = keep;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic feed(input int first, input int n, input bit stall);
      for (int i = first; i < first + n; i++) begin
         int gap;
         gap = 0;
         if (stall) gap = (i % 2 == 1) ? 2 : int'($urandom_range(0, 1));
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            chk("in_ready_gap", in_ready, 1'b1);
            @(negedge clk);
         end
         in_valid = 1'b1;
         for (int r = 0; r < ROWS; r++) in_a[r*WIDTH +: WIDTH] = op_a[i][r];
         for (int c = 0; c < COLS; c++) in_b[c*WIDTH +: WIDTH] = op_b[i][c];
         chk("in_ready_load", in_ready, 1'b1);
         @(negedge clk);
      end
      in_valid = 1'b0; in_a = '0; in_b = '0;
   endtask

   task automatic wait_out(input int exp_wait);
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      chk("out_valid_seen", out_valid, 1'b1);
      chk("wait_cycles", 64'(cnt), 64'(exp_wait));
   endtask

   task automatic drain(input int stall);
      for (int r = 0; r < ROWS; r++) begin
         for (int s = 0; s <= stall; s++) begin
            out_ready = (s == stall);
            chk("out_valid_drain", out_valid, 1'b1);
            chk("out_row_idx", 64'(out_row_idx), 64'(r));
            for (int c = 0; c < COLS; c++)
               chk("out_row", 64'(out_row[c*ACC_WIDTH +: ACC_WIDTH]), 64'(exp_c[r][c]));
            @(negedge clk);
         end
      end
      out_ready = 1'b0;
      chk("done_pulse", done, 1'b1);
      chk("busy_end", busy, 1'b0);
      chk("out_valid_end", out_valid, 1'b0);
      @(negedge clk);
      chk("done_once", done, 1'b0);
   endtask

   task automatic fill_const(input logic [WIDTH-1:0] v, input logic [ACC_WIDTH-1:0] e);
      for (int k = 0; k < K_MAX; k++) begin
         for (int r = 0; r < ROWS; r++) op_a[k][r] = v;
         for (int c = 0; c < COLS; c++) op_b[k][c] = v;
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_c[r][c] = e;
   endtask

   // Signed reference dot product over beats [lo, hi).
   task automatic model(input int lo, input int hi);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            longint s;
            s = 0;
            for (int k = lo; k < hi; k++)
               s += longint'($signed(op_a[k][r])) * longint'($signed(op_b[k][c]));
            exp_c[r][c] = ACC_WIDTH'(s);
         end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; k_len = '0; is_signed = 1'b0; acc_keep = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_row_idx", 64'(out_row_idx), 64'd0);
      reset = 1'b0;

      // Identity A, B rows 1+c+4k: result rows equal B rows.
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) op_a[k][r] = (r == k) ? 16'd1 : 16'd0;
         for (int c = 0; c < COLS; c++) op_b[k][c] = WIDTH'(1 + c + 4*k);
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_c[r][c] = ACC_WIDTH'(1 + c + 4*r);
      start_run(4, 1'b0, 1'b0);
      feed(0, 4, 1'b0);
      chk("in_ready_flush", in_ready, 1'b0);
      wait_out(6);
      drain(0);

      // Same data with input gaps.
      start_run(4, 1'b0, 1'b0);
      feed(0, 4, 1'b1);
      chk("in_ready_flush", in_ready, 1'b0);
      wait_out(6);
      drain(0);

      // Output backpressure, 3 stalled cycles per row.
      start_run(4, 1'b0, 1'b0);
      feed(0, 4, 1'b0);
      wait_out(6);
      drain(3);

      // Signed: (-32768)^2 * 256 = 2^38.
      fill_const(16'h8000, 40'h40_0000_0000);
      start_run(256, 1'b1, 1'b0);
      feed(0, 256, 1'b0);
      chk("in_ready_flush", in_ready, 1'b0);
      wait_out(6);
      drain(0);

      // Unsigned 0xFFFF^2 * 256; k_len=511 clamps to 256 beats.
      fill_const(16'hFFFF, 40'hFF_FE00_0100);
      start_run(511, 1'b0, 1'b0);
      feed(0, 256, 1'b0);
      chk("in_ready_clamp", in_ready, 1'b0);
      wait_out(6);
      drain(0);

      // Accumulate across runs: k=2 then keep with k=3 equals one k=5 run.
      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < ROWS; r++) op_a[k][r] = WIDTH'(3*k - 5*r);
         for (int c = 0; c < COLS; c++) op_b[k][c] = WIDTH'(7 - 2*k + 3*c);
      end
      model(0, 2);
      start_run(2, 1'b1, 1'b0);
      feed(0, 2, 1'b0);
      wait_out(6);
      drain(0);
      model(0, 5);
      start_run(3, 1'b1, 1'b1);
      feed(2, 3, 1'b0);
      wait_out(6);
      drain(0);

      // Reset mid-LOAD, then a keep run of depth 0 must read back zeros.
      start_run(4, 1'b1, 1'b1);
      feed(0, 2, 1'b0);
      chk("busy_mid_load", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_c[r][c] = '0;
      start_run(0, 1'b0, 1'b1);
      wait_out(0);
      drain(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_array_skewed.md
# systolic_array_skewed

Parametrised ROWS×COLS output-stationary MAC grid with built-in input skew, a K-depth run controller and a row-serial result drain. Each PE holds one accumulator. Callers feed unskewed A columns and B rows with a valid/ready handshake and read back C = A·B one row per handshake. It sits between the operand buffers and the writeback path, replacing externally skewed array tiling, and adds:
- stall/backpressure
- signed/unsigned operands
- accumulate-across-runs for K-split matmuls

## Interface
Parameters:
- ROWS, 4, PE rows (A lanes)
- COLS, 4, PE columns (B lanes)
- WIDTH, 16, operand width
- ACC_WIDTH, 40, accumulator width (≥ 2·WIDTH)
- K_MAX, 256, maximum reduction depth per run
- KW, $clog2(K_MAX+1), k_len width

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- start  in  1  begin run; sampled only in IDLE
- k_len  in  KW  reduction depth; latched at start; values > K_MAX treated as K_MAX
- is_signed  in  1  latched at start; 1 = two's-complement operands, 0 = unsigned
- acc_keep  in  1  latched at start; 1 = keep accumulators, 0 = clear them
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_a  in  ROWS*WIDTH  lane r at [r*WIDTH +: WIDTH]
- in_b  in  COLS*WIDTH  lane c at [c*WIDTH +: WIDTH]
- out_valid  out  1  result row valid
- out_ready  in  1  result row consumed when out_valid & out_ready
- out_row  out  COLS*ACC_WIDTH  acc[out_row_idx][c] at [c*ACC_WIDTH +: ACC_WIDTH]
- out_row_idx  out  $clog2(ROWS) (min 1)  row being presented
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of drain

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - Sees start=1: latch k_len, is_signed and acc_keep; clear all accumulators unless acc_keep=1.
  - If k_len=0, go to DRAIN; otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted beat is one array step. With no beat, the array, skew lines and counters hold.
  - After the k_len-th accepted beat, go to FLUSH. If ROWS+COLS-2 = 0, go straight to DRAIN.
- FLUSH:
  - One array step per cycle, with zero operands injected.
  - Lasts exactly ROWS+COLS-2 cycles, then go to DRAIN.
- Skew on entry:
  - Lane r of in_a is delayed r steps before entering PE(r,0).
  - Lane c of in_b is delayed c steps before entering PE(0,c).
- Array step:
  - A operands move one column right; B operands move one row down.
  - Every PE performs acc += a·b on the operands it currently holds.
- Result: after FLUSH, acc[r][c] = (prior value if acc_keep, else 0) + Σ_k a_k[r]·b_k[c].
- Arithmetic:
  - Each product is extended to ACC_WIDTH per is_signed.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation and no overflow flag.
- DRAIN:
  - out_valid=1 and out_row_idx starts at 0.
  - Each handshake advances out_row_idx; out_row and out_row_idx hold while out_ready=0.
  - The handshake on row ROWS-1 returns the FSM to IDLE and asserts done the following cycle.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored, and no beat is consumed.
- Accumulators persist in IDLE. An acc_keep=1 run continues from the last run's values.
- Reset takes effect from any state, mid-run included:
  - state becomes IDLE;
  - accumulators, skew lines, PE operand registers and counters are cleared;
  - in_ready, out_valid, busy and done go to 0; out_row_idx goes to 0.

## Timing
- in_ready and out_valid are decoded from the registered state; there is no combinational in→out path.
- Start sampled at cycle S: busy=1 and in_ready=1 from S+1.
- Last beat accepted at cycle T:
  - FLUSH occupies T+1 … T+ROWS+COLS-2;
  - first out_valid is at T+ROWS+COLS-1.
- With k_len=0, out_valid is high at S+1.
- Last drain handshake at cycle D:
  - busy=0 at D+1;
  - done=1 at D+1 only;
  - the next start is accepted at D+1.
- Drain throughput is one row per cycle with out_ready held high.
- Minimum run length with no stalls: 1 + k_len + (ROWS+COLS-2) + ROWS cycles.

## Test plan
- Identity, 4×4, WIDTH=16, k_len=4:
  - stimulus: A=I, B rows = [1,2,3,4]+4k, no stalls;
  - required: rows read back equal B exactly; first out_valid 6 cycles after the last beat; done one cycle after row 3.
- Input stall:
  - stimulus: same data, in_valid toggled 1,0,0,1,… with random gaps;
  - required: results identical to the no-stall run; in_ready stays 1 throughout LOAD.
- Output backpressure:
  - stimulus: out_ready low for 3 cycles per row;
  - required: out_row and out_row_idx stable while stalled; rows arrive in order 0..3 with no duplicates or skips.
- Signed wrap, ACC_WIDTH=40, is_signed=1:
  - stimulus: all operands −32768, k_len=256;
  - required: every acc = 256·2^30 = 2^38.
- Unsigned, is_signed=0:
  - stimulus: all operands 0xFFFF, k_len=256;
  - required: every acc = 256·(2^16−1)^2 mod 2^40.
- Accumulate and reset:
  - stimulus: a k_len=2 run, then acc_keep=1 with k_len=3 on the same data pattern;
  - required: results equal a single k_len=5 run.
  - stimulus: reset asserted mid-LOAD, then a fresh acc_keep=1 run;
  - required: the fresh run starts from zero accumulators; k_len=0 returns all-zero rows.
